// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - March C- BIST shared types and per-element tables
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } mbist_state_e;

  typedef enum logic [2:0] {
    M0,
    M1,
    M2,
    M3,
    M4,
    M5
  } march_elem_e;

  localparam int BIST_OPS = 640;

  // One bit per element, indexed by march_elem_e.
  localparam logic [5:0] ELEM_UP      = 6'b000111;
  localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;
  localparam logic [5:0] ELEM_RD_ONE  = 6'b010100;
  localparam logic [5:0] ELEM_WR_ONE  = 6'b001010;

  function automatic march_elem_e elem_succ(input march_elem_e e);
    return (e == M5) ? M5 : march_elem_e'(e + 3'd1);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// rtl/mbist_addr_gen.sv - up/down address counter with load and terminal flag
module mbist_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_up,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_up ? '0 : ADDR_MAX;
    end else if (en) begin
      addr <= up ? addr + 1'b1 : addr - 1'b1;
    end
  end

  // Terminal address depends on direction; the counter never wraps.
  assign tc = up ? (addr == ADDR_MAX) : (addr == '0);

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- BIST controller sharing a single-port SRAM
module mbist_march_ctrl #(
  parameter int                ADDR_W = 6,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG0    = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              func_cs,
  input  logic              func_rwbar,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic [DATA_W-1:0] func_din,
  output logic [DATA_W-1:0] func_dout,
  output logic              cs,
  output logic              rwbar,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  input  logic [DATA_W-1:0] ramout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data
);

  import mbist_pkg::*;

  mbist_state_e      state_q, state_d;
  march_elem_e       elem_q, elem_nx;
  logic              phase_q;
  logic [ADDR_W-1:0] addr;
  logic              tc;
  logic              run_start, in_run, two_ops, is_read, last_of_addr, elem_end;
  logic              ag_load, ag_load_up, ag_en;

  logic              pv_valid;
  logic [DATA_W-1:0] pv_exp;
  logic [ADDR_W-1:0] pv_addr;
  logic [2:0]        pv_elem;
  logic              miscompare;

  assign run_start    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_run       = (state_q == ST_RUN);
  assign two_ops      = ELEM_TWO_OPS[elem_q];
  assign is_read      = two_ops ? !phase_q : (elem_q == M5);
  assign last_of_addr = !two_ops || phase_q;
  assign elem_end     = in_run && last_of_addr && tc;
  assign elem_nx      = elem_succ(elem_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (run_start) state_d = ST_RUN;
      ST_RUN:           if (elem_end && (elem_q == M5)) state_d = ST_DRAIN;
      ST_DRAIN:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Within a two-op element phase 0 is the read and phase 1 the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q  <= M0;
      phase_q <= 1'b0;
    end else if (run_start) begin
      elem_q  <= M0;
      phase_q <= 1'b0;
    end else if (in_run) begin
      if (last_of_addr) begin
        phase_q <= 1'b0;
        if (tc) elem_q <= elem_nx;
      end else begin
        phase_q <= 1'b1;
      end
    end
  end

  assign ag_load    = run_start || (elem_end && (elem_q != M5));
  assign ag_load_up = run_start ? ELEM_UP[M0] : ELEM_UP[elem_nx];
  assign ag_en      = in_run && last_of_addr && !tc;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ag_load),
    .load_up (ag_load_up),
    .en      (ag_en),
    .up      (ELEM_UP[elem_q]),
    .addr    (addr),
    .tc      (tc)
  );

  assign busy      = in_run || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign func_dout = ramout;

  always_comb begin
    cs      = func_cs;
    rwbar   = func_rwbar;
    ramaddr = func_addr;
    ramin   = func_din;
    if (busy) begin
      cs      = in_run;
      rwbar   = is_read;
      ramaddr = addr;
      ramin   = ELEM_WR_ONE[elem_q] ? ~BG0 : BG0;
    end
  end

  // Read data returns a cycle late, so each read's context is held one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_valid <= 1'b0;
      pv_exp   <= '0;
      pv_addr  <= '0;
      pv_elem  <= '0;
    end else begin
      pv_valid <= in_run && is_read;
      pv_exp   <= ELEM_RD_ONE[elem_q] ? ~BG0 : BG0;
      pv_addr  <= addr;
      pv_elem  <= elem_q;
    end
  end

  assign miscompare = pv_valid && (ramout != pv_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (run_start) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (miscompare && !fail) begin
      fail      <= 1'b1;
      fail_addr <= pv_addr;
      fail_elem <= pv_elem;
      fail_data <= ramout;
    end
  end

endmodule
